// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared widths, stall bus type and fetch FSM encodings for ifetch
package ifetch_pkg;

  localparam int PC_TO_IC_WD = 65;
  localparam int IF_TO_ID_WD = 97;
  localparam int STALL_WD    = 6;

  // Bit positions inside the stall vector and the exception word
  localparam int STALL_IF_BIT = 1;
  localparam int STALL_ID_BIT = 2;
  localparam int ADEL_BIT     = 16;

  typedef logic [STALL_WD-1:0] stall_bus_t;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  // Assemble the IF->ID pipeline word {valid, excepttype, pc, inst}
  function automatic logic [IF_TO_ID_WD-1:0] pack_if_to_id(
    input logic        valid,
    input logic [31:0] excepttype,
    input logic [31:0] pc,
    input logic [31:0] inst
  );
    return {valid, excepttype, pc, inst};
  endfunction

endpackage

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage with single-outstanding SRAM request; IFETCH_PERF_CNT_EN enables the fetch-wait counter
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_WD-1:0]    stall,
  input  logic                   flush,
  input  logic [PC_TO_IC_WD-1:0] pc_to_ic_bus,
  output logic                   inst_sram_req,
  output logic [31:0]            inst_sram_addr,
  input  logic                   inst_sram_addr_ok,
  input  logic                   inst_sram_data_ok,
  input  logic [31:0]            inst_sram_rdata,
  output logic                   stallreq_if,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic [31:0]            perf_wait_cnt
);

  logic [31:0] excepttype;
  logic        ce;
  logic [31:0] pc;
  logic        adel;
  logic        stall_if;
  logic        stall_id;

  assign excepttype = pc_to_ic_bus[64:33];
  assign ce         = pc_to_ic_bus[32];
  assign pc         = pc_to_ic_bus[31:0];
  assign adel       = excepttype[ADEL_BIT];
  assign stall_if   = stall[STALL_IF_BIT];
  assign stall_id   = stall[STALL_ID_BIT];

  // Remaining stall bits belong to later stages
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5:3], stall[0]};

  assign inst_sram_addr = pc;

  fetch_state_e           state_q, state_d;
  logic                   discard_q, discard_d;
  logic [31:0]            hold_q, hold_d;
  logic [IF_TO_ID_WD-1:0] bus_q, bus_d;
  logic                   deliver;
  logic [31:0]            deliver_inst;

  // Register FSM state, discard flag, held word and the IF->ID bus
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH_REQ;
      discard_q <= 1'b0;
      hold_q    <= 32'h0;
      bus_q     <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      hold_q    <= hold_d;
      bus_q     <= bus_d;
    end
  end

  // Next-state, request/stall outputs and next IF->ID bus value
  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    hold_d        = hold_q;
    bus_d         = bus_q;
    deliver       = 1'b0;
    deliver_inst  = NOP_INST;
    inst_sram_req = 1'b0;
    stallreq_if   = 1'b0;

    case (state_q)
      FETCH_REQ: begin
        inst_sram_req = ce & ~adel & ~flush;
        stallreq_if   = inst_sram_req & ~inst_sram_addr_ok;
        if (flush) begin
          state_d = FETCH_REQ;
          hold_d  = 32'h0;
        end else if (inst_sram_req && inst_sram_addr_ok) begin
          state_d = FETCH_WAIT;
        end else if (ce && adel && !stall_if) begin
          // Misaligned fetch: no memory access, pass the exception down with a NOP
          deliver      = 1'b1;
          deliver_inst = NOP_INST;
        end
      end

      FETCH_WAIT: begin
        stallreq_if = ~inst_sram_data_ok | discard_q;
        if (inst_sram_data_ok) begin
          if (discard_q || flush) begin
            // Response belongs to a cancelled fetch
            state_d   = FETCH_REQ;
            discard_d = 1'b0;
          end else if (stall_if) begin
            hold_d  = inst_sram_rdata;
            state_d = FETCH_HOLD;
          end else begin
            deliver      = 1'b1;
            deliver_inst = inst_sram_rdata;
            state_d      = FETCH_REQ;
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end

      FETCH_HOLD: begin
        if (flush) begin
          state_d = FETCH_REQ;
          hold_d  = 32'h0;
        end else if (!stall_if) begin
          deliver      = 1'b1;
          deliver_inst = hold_q;
          state_d      = FETCH_REQ;
        end
      end

      default: begin
        state_d = FETCH_REQ;
      end
    endcase

    // Flush always squashes; ID-held keeps the bus; otherwise a bubble
    if (flush) begin
      bus_d = pack_if_to_id(1'b0, 32'h0, 32'h0, NOP_INST);
    end else if (deliver) begin
      bus_d = pack_if_to_id(1'b1, excepttype, pc, deliver_inst);
    end else if (stall_if && stall_id) begin
      bus_d = bus_q;
    end else begin
      bus_d = pack_if_to_id(1'b0, 32'h0, 32'h0, NOP_INST);
    end
  end

  assign if_to_id_bus = bus_q;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] wait_cnt_q;

  // Count every cycle the fetch stage holds the pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 32'h0;
    end else if (stallreq_if) begin
      wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign perf_wait_cnt = wait_cnt_q;
`else
  assign perf_wait_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed self-checking bench for ifetch
module tb_ifetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [64:0] pc_to_ic_bus;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        stallreq_if;
  logic [96:0] if_to_id_bus;
  logic [31:0] perf_wait_cnt;

  int checks   = 0;
  int failures = 0;

  ifetch #(.NOP_INST(NOP)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .pc_to_ic_bus      (pc_to_ic_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .stallreq_if       (stallreq_if),
    .if_to_id_bus      (if_to_id_bus),
    .perf_wait_cnt     (perf_wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [96:0] obs, input logic [96:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] pcb(input logic [31:0] ex, input logic ce, input logic [31:0] pc);
    return {ex, ce, pc};
  endfunction

  initial begin
    logic [31:0] exp_perf;

    rst = 1'b1; stall = 6'b0; flush = 1'b0;
    pc_to_ic_bus = pcb(32'h0, 1'b0, 32'h0);
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
    tick; tick;
    rst = 1'b0;
    #1;
    chk("reset_bus", if_to_id_bus, 97'h0);
    chk("reset_perf", 97'(perf_wait_cnt), 97'h0);
    chk("ce0_req", 97'(inst_sram_req), 97'h0);
    chk("ce0_stallreq", 97'(stallreq_if), 97'h0);
    tick;
    chk("ce0_bubble", if_to_id_bus, {1'b0, 32'h0, 32'h0, NOP});

    // Basic fetch: addr_ok in cycle 1, data_ok in cycle 3
    pc_to_ic_bus = pcb(32'h0, 1'b1, 32'hbfc00000);
    inst_sram_addr_ok = 1'b1;
    #1;
    chk("c1_req", 97'(inst_sram_req), 97'h1);
    chk("c1_addr", 97'(inst_sram_addr), 97'hbfc00000);
    chk("c1_stallreq", 97'(stallreq_if), 97'h0);
    tick;
    inst_sram_addr_ok = 1'b0;
    #1;
    chk("c2_req", 97'(inst_sram_req), 97'h0);
    chk("c2_stallreq", 97'(stallreq_if), 97'h1);
    tick;
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h24080001;
    #1;
    chk("c3_stallreq", 97'(stallreq_if), 97'h0);
    tick;
    inst_sram_data_ok = 1'b0;
    chk("c4_bus", if_to_id_bus, {1'b1, 32'h0, 32'hbfc00000, 32'h24080001});

    // Data returns while IF is stalled: word parked in HOLD
    pc_to_ic_bus = pcb(32'h0, 1'b1, 32'hbfc00004);
    inst_sram_addr_ok = 1'b1;
    tick;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h11111111;
    stall = 6'b000010;
    tick;
    inst_sram_data_ok = 1'b0;
    chk("hold_bubble", if_to_id_bus, {1'b0, 32'h0, 32'h0, NOP});
    #1;
    chk("hold_req", 97'(inst_sram_req), 97'h0);
    chk("hold_stallreq", 97'(stallreq_if), 97'h0);
    tick;
    stall = 6'b000110;
    tick;
    chk("hold_id_held", if_to_id_bus, {1'b0, 32'h0, 32'h0, NOP});
    stall = 6'b000010;
    tick;
    stall = 6'b000000;
    #1;
    chk("hold_release_req", 97'(inst_sram_req), 97'h0);
    tick;
    chk("hold_emit", if_to_id_bus, {1'b1, 32'h0, 32'hbfc00004, 32'h11111111});

    // Flush while waiting: the stale response is discarded
    pc_to_ic_bus = pcb(32'h0, 1'b1, 32'hbfc00008);
    inst_sram_addr_ok = 1'b1;
    tick;
    inst_sram_addr_ok = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_req", 97'(inst_sram_req), 97'h0);
    tick;
    flush = 1'b0;
    pc_to_ic_bus = pcb(32'h0, 1'b1, 32'hbfc00380);
    chk("flush_bus", 97'(if_to_id_bus[96]), 97'h0);
    tick;
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hdeadbeef;
    #1;
    chk("discard_stallreq", 97'(stallreq_if), 97'h1);
    tick;
    inst_sram_data_ok = 1'b0;
    chk("discard_no_valid", 97'(if_to_id_bus[96]), 97'h0);
    #1;
    chk("newpc_req", 97'(inst_sram_req), 97'h1);
    chk("newpc_addr", 97'(inst_sram_addr), 97'hbfc00380);
    inst_sram_addr_ok = 1'b1;
    tick;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'haaaa5555;
    tick;
    inst_sram_data_ok = 1'b0;
    chk("newpc_bus", if_to_id_bus, {1'b1, 32'h0, 32'hbfc00380, 32'haaaa5555});

    // Misaligned PC: no request, exception word with NOP
    pc_to_ic_bus = pcb(32'h00010000, 1'b1, 32'hbfc00002);
    #1;
    chk("adel_req", 97'(inst_sram_req), 97'h0);
    chk("adel_stallreq", 97'(stallreq_if), 97'h0);
    tick;
    chk("adel_bus", if_to_id_bus, {1'b1, 32'h00010000, 32'hbfc00002, NOP});

    // Reset while a request is outstanding
    pc_to_ic_bus = pcb(32'h0, 1'b1, 32'hbfc00000);
    inst_sram_addr_ok = 1'b1;
    tick;
    inst_sram_addr_ok = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_wait_bus", if_to_id_bus, 97'h0);
    #1;
    chk("rst_wait_req", 97'(inst_sram_req), 97'h1);
    pc_to_ic_bus = pcb(32'h0, 1'b0, 32'hbfc00000);
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h77777777;
    tick;
    inst_sram_data_ok = 1'b0;
    chk("late_dataok_ignored", if_to_id_bus, {1'b0, 32'h0, 32'h0, NOP});

    // Wait counter: addr_ok held low for 5 cycles from a fresh reset
    rst = 1'b1;
    tick;
    rst = 1'b0;
    pc_to_ic_bus = pcb(32'h0, 1'b1, 32'hbfc00000);
    for (int i = 0; i < 5; i++) tick;
`ifdef IFETCH_PERF_CNT_EN
    exp_perf = 32'd5;
`else
    exp_perf = 32'd0;
`endif
    chk("perf_5", 97'(perf_wait_cnt), 97'(exp_perf));
    inst_sram_addr_ok = 1'b1;
    tick;
    inst_sram_addr_ok = 1'b0;
    chk("perf_hold", 97'(perf_wait_cnt), 97'(exp_perf));
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h01234567;
    tick;
    inst_sram_data_ok = 1'b0;
    chk("perf_bus", if_to_id_bus, {1'b1, 32'h0, 32'hbfc00000, 32'h01234567});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
